// File: rtl/fundamental_bin_selector_pkg.sv
// fbin_pkg: shared types and field helpers for the fundamental bin selector.
//   fbin_state_t : frame FSM state (CAPTURE -> SCAN -> EMIT -> CAPTURE)
//   fbin_found_bit(bin_w) : position of the found flag in the result word;
//                           the bin index occupies bits [bin_w-1:0] below it.
package fbin_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    SCAN    = 2'd1,
    EMIT    = 2'd2
  } fbin_state_t;

  function automatic int fbin_found_bit(input int bin_w);
    return bin_w;
  endfunction

endpackage

// File: rtl/fundamental_bin_selector_buffer.sv
// bin_frame_buffer: one-frame store of per-bin samples.
// One synchronous write port and one asynchronous (combinational) read port,
// so a consumer can examine one entry per cycle with no read latency.
//   clk     in  clock
//   we_i    in  write enable
//   waddr_i in  write address
//   wdata_i in  write data
//   raddr_i in  read address
//   rdata_o out read data (combinational from raddr_i)
module bin_frame_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 88,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents need no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fundamental_bin_selector.sv
// fundamental_bin_selector: per frame, captures N_BINS joined (mag, sal)
// samples while tracking their maxima, then scans upward from MIN_BIN for the
// first bin with sal >= max_sal >> SAL_SHIFT and mag > max_mag >> MAG_SHIFT,
// and emits one {found, bin} word.
//
// Handshake: a stream word transfers on a rising clk edge where its valid and
// ready are both high. valid never depends on ready; once raised, valid and
// data hold until the transfer.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mag_valid_i/_data_i   magnitude stream in, bin 0 first; mag_ready_o out
//   sal_valid_i/_data_i   salience stream in, index-aligned with mag;
//                         sal_ready_o out
//   dout_valid_o/_data_o  result word {found, bin} out; dout_ready_i in
//   state_o               current FSM state (debug)
module fundamental_bin_selector
  import fbin_pkg::*;
#(
  parameter int N_BINS    = 32,
  parameter int MIN_BIN   = 1,
  parameter int MAG_WIDTH = 24,
  parameter int SAL_WIDTH = 64,
  parameter int MAG_SHIFT = 8,
  parameter int SAL_SHIFT = 10,
  localparam int BIN_W    = $clog2(N_BINS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mag_valid_i,
  input  logic [MAG_WIDTH-1:0] mag_data_i,
  output logic                 mag_ready_o,
  input  logic                 sal_valid_i,
  input  logic [SAL_WIDTH-1:0] sal_data_i,
  output logic                 sal_ready_o,
  output logic                 dout_valid_o,
  output logic [BIN_W:0]       dout_data_o,
  input  logic                 dout_ready_i,
  output fbin_state_t          state_o
);

  localparam int FOUND_BIT = fbin_found_bit(BIN_W);
  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(N_BINS - 1);
  localparam logic [BIN_W-1:0] MIN_IDX  = BIN_W'(MIN_BIN);

  fbin_state_t          state_q, state_d;
  logic [BIN_W-1:0]     cap_idx_q, cap_idx_d;
  logic [BIN_W-1:0]     scan_idx_q, scan_idx_d;
  logic [MAG_WIDTH-1:0] max_mag_q, max_mag_d;
  logic [SAL_WIDTH-1:0] max_sal_q, max_sal_d;
  logic [MAG_WIDTH-1:0] mag_thr_q, mag_thr_d;
  logic [SAL_WIDTH-1:0] sal_thr_q, sal_thr_d;
  logic                 thr_rdy_q, thr_rdy_d;
  logic [BIN_W:0]       res_q, res_d;

  logic                           accept;
  logic [MAG_WIDTH+SAL_WIDTH-1:0] rd_word;
  logic [MAG_WIDTH-1:0]           rd_mag;
  logic [SAL_WIDTH-1:0]           rd_sal;
  logic                           qualify;

  // The two streams are joined: each side's ready follows the other's valid,
  // so a bin is consumed only when both halves are present. Ready is forced
  // low while reset is held so nothing can transfer during reset.
  assign mag_ready_o = (state_q == CAPTURE) && sal_valid_i && !reset;
  assign sal_ready_o = (state_q == CAPTURE) && mag_valid_i && !reset;
  assign accept      = (state_q == CAPTURE) && mag_valid_i && sal_valid_i;

  assign dout_valid_o = (state_q == EMIT);
  assign dout_data_o  = res_q;
  assign state_o      = state_q;

  bin_frame_buffer #(
    .DEPTH (N_BINS),
    .WIDTH (MAG_WIDTH + SAL_WIDTH)
  ) u_buf (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (cap_idx_q),
    .wdata_i ({mag_data_i, sal_data_i}),
    .raddr_i (scan_idx_q),
    .rdata_o (rd_word)
  );

  assign rd_mag  = rd_word[SAL_WIDTH +: MAG_WIDTH];
  assign rd_sal  = rd_word[SAL_WIDTH-1:0];
  assign qualify = (rd_sal >= sal_thr_q) && (rd_mag > mag_thr_q);

  always_comb begin
    state_d    = state_q;
    cap_idx_d  = cap_idx_q;
    scan_idx_d = scan_idx_q;
    max_mag_d  = max_mag_q;
    max_sal_d  = max_sal_q;
    mag_thr_d  = mag_thr_q;
    sal_thr_d  = sal_thr_q;
    thr_rdy_d  = thr_rdy_q;
    res_d      = res_q;
    case (state_q)
      CAPTURE: begin
        if (accept) begin
          // Strictly greater: a tie keeps the earlier maximum.
          if (mag_data_i > max_mag_q) max_mag_d = mag_data_i;
          if (sal_data_i > max_sal_q) max_sal_d = sal_data_i;
          if (cap_idx_q == LAST_IDX) begin
            cap_idx_d  = '0;
            scan_idx_d = MIN_IDX;
            thr_rdy_d  = 1'b0;
            state_d    = SCAN;
          end else begin
            cap_idx_d = cap_idx_q + 1'b1;
          end
        end
      end
      SCAN: begin
        // First SCAN cycle registers both thresholds once per frame so the
        // shift stays off the per-bin compare path; bins are examined from
        // the following cycle on.
        if (!thr_rdy_q) begin
          mag_thr_d = max_mag_q >> MAG_SHIFT;
          sal_thr_d = max_sal_q >> SAL_SHIFT;
          thr_rdy_d = 1'b1;
        end else if (qualify) begin
          res_d                   = '0;
          res_d[FOUND_BIT]        = 1'b1;
          res_d[BIN_W-1:0]        = scan_idx_q;
          state_d                 = EMIT;
        end else if (scan_idx_q == LAST_IDX) begin
          res_d   = '0;
          state_d = EMIT;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      EMIT: begin
        if (dout_ready_i) begin
          max_mag_d = '0;
          max_sal_d = '0;
          state_d   = CAPTURE;
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CAPTURE;
      cap_idx_q  <= '0;
      scan_idx_q <= '0;
      max_mag_q  <= '0;
      max_sal_q  <= '0;
      mag_thr_q  <= '0;
      sal_thr_q  <= '0;
      thr_rdy_q  <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cap_idx_q  <= cap_idx_d;
      scan_idx_q <= scan_idx_d;
      max_mag_q  <= max_mag_d;
      max_sal_q  <= max_sal_d;
      mag_thr_q  <= mag_thr_d;
      sal_thr_q  <= sal_thr_d;
      thr_rdy_q  <= thr_rdy_d;
      res_q      <= res_d;
    end
  end

endmodule

// File: tb/tb_fundamental_bin_selector.sv
module tb_fundamental_bin_selector;
  import fbin_pkg::*;

  localparam int MW = 24;
  localparam int SW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: default parameters (N_BINS=32, MIN_BIN=1)
  logic          a_mag_valid = 0, a_sal_valid = 0, a_dout_ready = 1;
  logic [MW-1:0] a_mag_data = '0;
  logic [SW-1:0] a_sal_data = '0;
  logic          a_mag_ready, a_sal_ready, a_dout_valid;
  logic [5:0]    a_dout_data;
  fbin_state_t   a_state;

  // DUT B: N_BINS=64, MIN_BIN=4
  logic          b_mag_valid = 0, b_sal_valid = 0, b_dout_ready = 1;
  logic [MW-1:0] b_mag_data = '0;
  logic [SW-1:0] b_sal_data = '0;
  logic          b_mag_ready, b_sal_ready, b_dout_valid;
  logic [6:0]    b_dout_data;
  fbin_state_t   b_state;

  fundamental_bin_selector u_dut_a (
    .clk(clk), .reset(reset),
    .mag_valid_i(a_mag_valid), .mag_data_i(a_mag_data), .mag_ready_o(a_mag_ready),
    .sal_valid_i(a_sal_valid), .sal_data_i(a_sal_data), .sal_ready_o(a_sal_ready),
    .dout_valid_o(a_dout_valid), .dout_data_o(a_dout_data), .dout_ready_i(a_dout_ready),
    .state_o(a_state)
  );

  fundamental_bin_selector #(.N_BINS(64), .MIN_BIN(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .mag_valid_i(b_mag_valid), .mag_data_i(b_mag_data), .mag_ready_o(b_mag_ready),
    .sal_valid_i(b_sal_valid), .sal_data_i(b_sal_data), .sal_ready_o(b_sal_ready),
    .dout_valid_o(b_dout_valid), .dout_data_o(b_dout_data), .dout_ready_i(b_dout_ready),
    .state_o(b_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [5:0] a_exp_q[$];
  int         a_lat_q[$];
  logic [6:0] b_exp_q[$];
  int         b_lat_q[$];
  int a_hs_cyc = 0, b_hs_cyc = 0;
  bit a_in_word = 0, b_in_word = 0;
  logic [5:0] a_held = '0;
  logic [6:0] b_held = '0;

  logic [MW-1:0] fm [64];
  logic [SW-1:0] fs [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at #1 after a rising edge.
  task automatic send_bin(input bit use_b, input logic [MW-1:0] m, input logic [SW-1:0] s,
                          input bit gaps);
    bit hs;
    int guard;
    logic mv, sv;
    hs = 0;
    guard = 0;
    while (!hs && guard < 200) begin
      mv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      sv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (use_b) begin
        b_mag_valid = mv; b_sal_valid = sv; b_mag_data = m; b_sal_data = s;
      end else begin
        a_mag_valid = mv; a_sal_valid = sv; a_mag_data = m; a_sal_data = s;
      end
      @(negedge clk);
      hs = use_b ? (b_mag_valid && b_sal_valid && b_mag_ready && b_sal_ready)
                 : (a_mag_valid && a_sal_valid && a_mag_ready && a_sal_ready);
      @(posedge clk); #1;
      guard++;
    end
    if (use_b) begin b_mag_valid = 0; b_sal_valid = 0; b_hs_cyc = cyc; end
    else       begin a_mag_valid = 0; a_sal_valid = 0; a_hs_cyc = cyc; end
    if (!hs) check("input_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_frame(input logic [MW-1:0] m, input logic [SW-1:0] s);
    for (int i = 0; i < 64; i++) begin fm[i] = m; fs[i] = s; end
  endtask

  task automatic send_frame(input bit use_b, input int n, input bit gaps);
    for (int i = 0; i < n; i++) send_bin(use_b, fm[i], fs[i], gaps);
  endtask

  task automatic expect_a(input logic [5:0] word, input int lat);
    a_exp_q.push_back(word); a_lat_q.push_back(lat);
  endtask

  task automatic expect_b(input logic [6:0] word, input int lat);
    b_exp_q.push_back(word); b_lat_q.push_back(lat);
  endtask

  task automatic wait_idle(input bit use_b);
    int guard;
    guard = 0;
    while (guard < 300 && (use_b ? (b_exp_q.size() != 0 || b_in_word)
                                 : (a_exp_q.size() != 0 || a_in_word))) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) check(use_b ? "b_output_timeout" : "a_output_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (reset) a_in_word = 0;
    else if (a_dout_valid) begin
      check("a_inputs_stalled_in_emit", {62'd0, a_mag_ready, a_sal_ready}, 64'd0);
      if (!a_in_word) begin
        a_in_word = 1;
        if (a_exp_q.size() == 0) check("a_unexpected_output", 64'd1, 64'd0);
        else begin
          a_held = a_exp_q.pop_front();
          check("a_dout_data", 64'(a_dout_data), 64'(a_held));
          check("a_latency", 64'(cyc - a_hs_cyc), 64'(a_lat_q.pop_front()));
        end
      end else begin
        check("a_dout_held_stable", 64'(a_dout_data), 64'(a_held));
      end
      if (a_dout_ready) a_in_word = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) b_in_word = 0;
    else if (b_dout_valid) begin
      check("b_inputs_stalled_in_emit", {62'd0, b_mag_ready, b_sal_ready}, 64'd0);
      if (!b_in_word) begin
        b_in_word = 1;
        if (b_exp_q.size() == 0) check("b_unexpected_output", 64'd1, 64'd0);
        else begin
          b_held = b_exp_q.pop_front();
          check("b_dout_data", 64'(b_dout_data), 64'(b_held));
          check("b_latency", 64'(cyc - b_hs_cyc), 64'(b_lat_q.pop_front()));
        end
      end else begin
        check("b_dout_held_stable", 64'(b_dout_data), 64'(b_held));
      end
      if (b_dout_ready) b_in_word = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g;
    @(posedge clk); #1;
    check("rst_dout_valid", 64'(a_dout_valid), 64'd0);
    check("rst_dout_data", 64'(a_dout_data), 64'd0);
    check("rst_ready", {62'd0, a_mag_ready, a_sal_ready}, 64'd0);
    check("rst_state", 64'(a_state), 64'(CAPTURE));
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // Single peak at bin 5: thresholds 3 / 1024 -> {1,5}, latency (5-1)+2
    clear_frame(24'd1, 64'd0);
    fm[5] = 24'd1000; fs[5] = 64'd1 << 20;
    expect_a({1'b1, 5'd5}, 6);
    send_frame(0, 32, 0);
    wait_idle(0);

    // DC skip: bin 0 holds both maxima; bin 3 = max/128, max/512 -> {1,3}
    clear_frame(24'd1, 64'd0);
    fm[0] = 24'd1048576; fs[0] = 64'd1 << 30;
    fm[3] = 24'd8192;    fs[3] = 64'd1 << 21;
    expect_a({1'b1, 5'd3}, 4);
    send_frame(0, 32, 0);
    wait_idle(0);

    // All-zero frame: nothing qualifies, latency (32-1)+1
    clear_frame(24'd0, 64'd0);
    expect_a(6'd0, 32);
    send_frame(0, 32, 0);
    wait_idle(0);

    // Small-value frame: only found if maxima were cleared after last frame
    clear_frame(24'd0, 64'd0);
    fm[9] = 24'd2; fs[9] = 64'd5;
    expect_a({1'b1, 5'd9}, 10);
    send_frame(0, 32, 0);
    wait_idle(0);

    // Gapped input plus 20 cycles of output backpressure
    a_dout_ready = 0;
    clear_frame(24'd1, 64'd0);
    fm[5] = 24'd1000; fs[5] = 64'd1 << 20;
    expect_a({1'b1, 5'd5}, 6);
    send_frame(0, 32, 1);
    g = 0;
    while (!a_dout_valid && g < 100) begin @(posedge clk); #1; g++; end
    check("bp_valid_seen", 64'(a_dout_valid), 64'd1);
    a_mag_valid = 1; a_sal_valid = 1;
    a_mag_data = 24'hABCDEF; a_sal_data = 64'hFFFF;
    repeat (20) begin @(posedge clk); #1; end
    a_mag_valid = 0; a_sal_valid = 0;
    a_dout_ready = 1;
    wait_idle(0);

    // Reset after 10 bins of a frame that would poison the maxima
    clear_frame(24'd1, 64'd0);
    fm[0] = 24'd1048576; fs[0] = 64'd1 << 30;
    for (int i = 0; i < 10; i++) send_bin(0, fm[i], fs[i], 0);
    a_mag_valid = 1; a_sal_valid = 1;
    reset = 1;
    #1;
    check("midrst_ready", {62'd0, a_mag_ready, a_sal_ready}, 64'd0);
    check("midrst_dout_valid", 64'(a_dout_valid), 64'd0);
    check("midrst_dout_data", 64'(a_dout_data), 64'd0);
    check("midrst_state", 64'(a_state), 64'(CAPTURE));
    @(posedge clk); #1;
    reset = 0;
    a_mag_valid = 0; a_sal_valid = 0;
    @(posedge clk); #1;
    clear_frame(24'd1, 64'd0);
    fm[5] = 24'd1000; fs[5] = 64'd1 << 20;
    expect_a({1'b1, 5'd5}, 6);
    send_frame(0, 32, 0);
    wait_idle(0);

    // N_BINS=64, MIN_BIN=4: peak at last bin -> {1,63}, latency (63-4)+2
    clear_frame(24'd1, 64'd0);
    fm[63] = 24'd1000; fs[63] = 64'd1 << 20;
    expect_b({1'b1, 6'd63}, 61);
    send_frame(1, 64, 0);
    wait_idle(1);

    // Peak only below MIN_BIN -> {0,0}, latency (64-4)+1
    clear_frame(24'd1, 64'd0);
    fm[2] = 24'd1000; fs[2] = 64'd1 << 20;
    expect_b(7'd0, 61);
    send_frame(1, 64, 0);
    wait_idle(1);

    check("a_queue_drained", 64'(a_exp_q.size()), 64'd0);
    check("b_queue_drained", 64'(b_exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fundamental_bin_selector.md
# fundamental_bin_selector

Parametrised fundamental-bin picker for the pitch pipeline. Each frame it collects N_BINS magnitude and salience values, tracks the per-frame maxima, then scans upward from MIN_BIN for the first bin that clears both relative thresholds. It sits after the HPS/peakiness/threshold salience stage. It emits one result word per frame with a found flag, honours output backpressure, and re-arms for the next frame automatically.

## Interface
- N_BINS, 32: bins per frame; power of two, >= 4
- MIN_BIN, 1: first bin the scan examines; bins below it are stored but never selected; 0 <= MIN_BIN < N_BINS
- MAG_WIDTH, 24: magnitude sample width, unsigned
- SAL_WIDTH, 64: salience×HPS sample width, unsigned
- MAG_SHIFT, 8: magnitude threshold = max_mag >> MAG_SHIFT
- SAL_SHIFT, 10: salience threshold = max_sal >> SAL_SHIFT
- BIN_W (derived), $clog2(N_BINS)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domain
- mag  Axis_If.Slave  MAG_WIDTH  raw magnitude per bin, bin 0 first
- sal  Axis_If.Slave  SAL_WIDTH  salience per bin, aligned index-for-index with mag
- dout  Axis_If.Master  BIN_W+1  {found, bin}; one word per frame

## Operation
- The FSM has three states: CAPTURE, SCAN and EMIT. Reset state is CAPTURE.
- CAPTURE:
  - mag.ready = sal.valid and sal.ready = mag.valid; both are 0 outside CAPTURE.
  - A bin is accepted only when mag.valid & sal.valid; the two streams are joined and never consumed separately.
  - On acceptance, the bin is written to the buffer at cap_idx.
  - max_mag and max_sal update on strictly greater values, so a tie keeps the old value.
  - cap_idx then increments.
  - On accepting bin N_BINS-1, cap_idx wraps to 0, scan_idx loads MIN_BIN, and the FSM goes to SCAN.
  - The maxima include the final bin.
- SCAN: one bin is examined per cycle at scan_idx.
  - Qualify condition: sal[k] >= (max_sal >> SAL_SHIFT) and mag[k] > (max_mag >> MAG_SHIFT).
  - Shifts are logical at full width, and comparisons are unsigned.
  - If bin k qualifies, register {1'b1, k} and go to EMIT.
  - If bin k does not qualify and k == N_BINS-1, register {1'b0, '0} and go to EMIT.
  - Otherwise increment scan_idx.
- EMIT: dout.valid = 1 and dout.data is held stable until dout.ready.
  - On the handshake, clear max_mag and max_sal to 0 and return to CAPTURE.
- Boundary cases:
  - All-zero frame: the magnitude test (0 > 0) fails everywhere, so the result is found = 0.
  - MIN_BIN = N_BINS-1: exactly one bin is examined.
  - No input is accepted during SCAN or EMIT. Upstream stalls, and no data is dropped.
  - Reset mid-frame discards the partial frame; the next accepted bin is treated as bin 0.

## Timing
- Reset values (asynchronous, immediate):
  - dout.valid = 0, dout.data = 0
  - mag.ready = 0, sal.ready = 0
  - state CAPTURE
  - cap_idx = 0, scan_idx = 0, max_mag = 0, max_sal = 0
- Capture throughput is 1 bin/cycle when both inputs are valid.
- Latency runs from the last-bin handshake edge to the first dout.valid cycle:
  - (k - MIN_BIN) + 2 cycles when bin k is found;
  - (N_BINS - MIN_BIN) + 1 cycles when nothing is found.
- The first bin of the next frame can be accepted in the cycle after the dout handshake.
- Buffer reads are combinational (distributed RAM) so that one bin is examined per cycle. Each buffer entry is one write and one read per frame.
- The dout.valid rule is AXI-compliant: it never depends on dout.ready.

## Structure
- Package fbin_pkg contains:
  - enum fbin_state_t {CAPTURE, SCAN, EMIT};
  - the result-word field offsets (FOUND_BIT = BIN_W).
- Sub-module bin_frame_buffer: parametrised depth N_BINS, width MAG_WIDTH+SAL_WIDTH, one write port and one asynchronous read port. It is reused by the harmonic tracker.
- All remaining logic (FSM, counters, maxima, comparators) lives in fundamental_bin_selector.

## Test plan
- Single peak, default params:
  - Stimulus: mag = 1000 at bin 5 and 1 elsewhere; sal = 2^20 at bin 5 and 0 elsewhere.
  - Required: dout = {1, 5}; dout.valid exactly 6 cycles after the last handshake.
- DC skip:
  - Stimulus: the largest mag and sal are at bin 0; bin 3 has mag = max/128 and sal = max/512.
  - Required: dout = {1, 3}. Bin 0 is never reported with MIN_BIN = 1.
- All-zero frame:
  - Required: dout = {0, 0} after 32 cycles.
  - The next frame is accepted normally, and the maxima are proven cleared by a small-value frame yielding its correct bin.
- Backpressure and gaps:
  - Stimulus: toggle mag.valid and sal.valid independently and randomly; hold dout.ready = 0 for 20 cycles.
  - Required: dout.data is stable while held; no input is accepted during EMIT; the result is identical to the ungapped run.
- Reset mid-frame:
  - Stimulus: assert reset after 10 bins, then send a full frame.
  - Required: outputs clear in the reset cycle, and the result reflects only the new frame.
- Param sweep, N_BINS = 64 and MIN_BIN = 4:
  - Stimulus: a peak at bin 63.
  - Required: {1, 63} with 61 cycles latency; a peak at bin 2 alone yields {0, 0}.
